// File: rtl/i2s_rx.sv
// i2s_rx: Philips-format I2S slave receiver; stereo pairs out through a valid/ready handshake.
// Define I2S_RX_OVERRUN_EN to add a sticky overrun flag for unaccepted overwrites.
module i2s_rx #(
    parameter int MAX_WL      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        word_length,
    input  logic              bit_clk,
    input  logic              frame_clk,
    input  logic              data,
    output logic [MAX_WL-1:0] left_sample,
    output logic [MAX_WL-1:0] right_sample,
    output logic              sample_valid,
    input  logic              sample_ready
`ifdef I2S_RX_OVERRUN_EN
    ,
    output logic              overrun
`endif
);
    localparam int CW = $clog2(MAX_WL + 1);
    localparam logic [7:0] MAX8 = 8'(MAX_WL);

    typedef enum logic [1:0] {IDLE, LEFT, RIGHT} state_t;

    state_t                 state, state_nxt;
    logic [SYNC_STAGES-1:0] bclk_sync, ws_sync, d_sync;
    logic                   bclk_prev, ws_prev;
    logic [MAX_WL-1:0]      shift, shift_nxt, left_stage;
    logic [CW-1:0]          cnt, wl_cur, wl_in;
    logic                   rise, ws, d, ws_change, commit_left, commit_pair;

    assign rise      = bclk_sync[SYNC_STAGES-1] & ~bclk_prev;
    assign ws        = ws_sync[SYNC_STAGES-1];
    assign d         = d_sync[SYNC_STAGES-1];
    assign ws_change = rise && (ws != ws_prev);
    assign wl_in     = (word_length == 8'd0 || word_length > MAX8) ? CW'(MAX_WL) : CW'(word_length);

    // Current bit lands MSB-first; the committed word is taken from here so the
    // last bit of a slot (arriving with the ws change) is included.
    always_comb begin
        shift_nxt = shift;
        for (int i = 0; i < MAX_WL; i++)
            if (cnt < wl_cur && cnt == CW'(MAX_WL - 1 - i)) shift_nxt[i] = d;
    end

    always_comb begin
        commit_left = ws_change && state == LEFT;
        commit_pair = ws_change && state == RIGHT;
        state_nxt   = !ws_change ? state :
                      state == IDLE ? (ws ? IDLE : LEFT) :
                      state == LEFT ? RIGHT :
                      state == RIGHT ? LEFT : IDLE;
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= IDLE;
        else state <= state_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bclk_sync    <= '0;
            ws_sync      <= '0;
            d_sync       <= '0;
            bclk_prev    <= 1'b0;
            ws_prev      <= 1'b0;
            shift        <= '0;
            cnt          <= '0;
            wl_cur       <= CW'(MAX_WL);
            left_stage   <= '0;
            left_sample  <= '0;
            right_sample <= '0;
            sample_valid <= 1'b0;
        end else begin
            bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], bit_clk};
            ws_sync   <= {ws_sync[SYNC_STAGES-2:0], frame_clk};
            d_sync    <= {d_sync[SYNC_STAGES-2:0], data};
            bclk_prev <= bclk_sync[SYNC_STAGES-1];
            if (rise) begin
                ws_prev <= ws;
                shift   <= ws_change ? '0 : shift_nxt;
                cnt     <= ws_change ? '0 : (cnt < wl_cur ? cnt + 1'b1 : cnt);
                if (ws_change) wl_cur <= wl_in;
            end
            if (commit_left) left_stage <= shift_nxt;
            if (commit_pair) begin
                left_sample  <= left_stage;
                right_sample <= shift_nxt;
                sample_valid <= 1'b1;
            end else if (sample_ready) begin
                sample_valid <= 1'b0;
            end
        end
    end

`ifdef I2S_RX_OVERRUN_EN
    always_ff @(posedge clk or negedge reset)
        if (!reset) overrun <= 1'b0;
        else if (commit_pair && sample_valid && !sample_ready) overrun <= 1'b1;
`endif
endmodule

// File: tb/tb_i2s_rx.sv
// tb_i2s_rx: randomized and directed I2S frames against a bit-level reference model;
// a monitor pops expected pairs from a scoreboard queue on every accepted output.
module tb_i2s_rx;
    localparam int BHALF = 50;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  word_length = 8'd16;
    logic        bit_clk = 1'b0;
    logic        frame_clk = 1'b0;
    logic        data = 1'b0;
    logic [15:0] left_sample, right_sample;
    logic        sample_valid;
    logic        sample_ready = 1'b1;
`ifdef I2S_RX_OVERRUN_EN
    logic        overrun;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    bit          ws_q[$];
    bit          dat_q[$];
    logic [7:0]  wl_q[$];

    i2s_rx #(.MAX_WL(16), .SYNC_STAGES(2)) dut (
        .clk(clk),
        .reset(reset),
        .word_length(word_length),
        .bit_clk(bit_clk),
        .frame_clk(frame_clk),
        .data(data),
        .left_sample(left_sample),
        .right_sample(right_sample),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready)
`ifdef I2S_RX_OVERRUN_EN
        ,
        .overrun(overrun)
`endif
    );

    always #5 clk = ~clk;

    // Expected word: the first min(slot, effective wl) bits of the slot, MSB-aligned, rest zero.
    function automatic logic [15:0] model(input int unsigned val, input int s, input int wl);
        int eff;
        int n;
        int unsigned top;
        eff = (wl == 0 || wl > 16) ? 16 : wl;
        n   = (s < eff) ? s : eff;
        top = val >> (s - n);
        return 16'(top << (16 - n));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset && sample_valid && sample_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pair: got %h/%h expected none", left_sample, right_sample);
            end else begin
                chk("pair", {left_sample, right_sample}, exp_q.pop_front());
            end
        end
    end

    // A slot is s bit periods of constant ws; word_length is only meaningful on the first one.
    task automatic add_slot(input bit w, input int unsigned val, input int s, input int wl);
        for (int i = s - 1; i >= 0; i--) begin
            ws_q.push_back(w);
            dat_q.push_back(((val >> i) & 1) != 0);
            wl_q.push_back((i == s - 1 && wl >= 0) ? 8'(wl) : 8'($urandom_range(0, 255)));
        end
    endtask

    task automatic add_frame(input int unsigned l, input int unsigned r, input int s, input int wl, input bit push);
        add_slot(1'b0, l, s, wl);
        add_slot(1'b1, r, s, wl);
        if (push) exp_q.push_back({model(l, s, wl), model(r, s, wl)});
    endtask

    task automatic new_stream();
        ws_q.delete();
        dat_q.delete();
        wl_q.delete();
        add_slot(1'b1, 0, 4, -1);
    endtask

    // Data lags ws by one bit period (Philips delay).
    task automatic play(input int from, input int to);
        for (int p = from; p < to; p++) begin
            frame_clk   = ws_q[p];
            data        = (p == 0) ? 1'b0 : dat_q[p-1];
            word_length = wl_q[p];
            #BHALF bit_clk = 1'b1;
            #BHALF bit_clk = 1'b0;
        end
    endtask

    task automatic run_all();
        add_slot(1'b0, 0, 1, -1);
        play(0, ws_q.size());
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #20;
        reset = 1'b1;
        #13;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s drain: got %0d pairs pending expected 0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(negedge clk);
        chk({name, " valid_drop"}, 32'(sample_valid), 32'd0);
    endtask

    initial begin
        int s, wl;
        int unsigned l, r, mask;
        #23;
        chk("reset left", 32'(left_sample), 32'd0);
        chk("reset right", 32'(right_sample), 32'd0);
        chk("reset valid", 32'(sample_valid), 32'd0);
`ifdef I2S_RX_OVERRUN_EN
        chk("reset overrun", 32'(overrun), 32'd0);
`endif
        reset = 1'b1;
        #10;

        new_stream();
        add_frame(32'hA5C3, 32'h1234, 16, 16, 1'b1);
        run_all();
        drain("t1_full");
`ifdef I2S_RX_OVERRUN_EN
        chk("t1 overrun", 32'(overrun), 32'd0);
`endif

        do_reset();
        new_stream();
        add_frame(32'hA5FF, 32'h3CFF, 16, 8, 1'b1);
        run_all();
        drain("t2_wl8");

        do_reset();
        new_stream();
        add_frame(32'hABC, 32'h123, 12, 16, 1'b1);
        run_all();
        drain("t3_short_slot");

        do_reset();
        new_stream();
        add_frame(32'hBEEF, 32'hCAFE, 16, 0, 1'b1);
        add_frame(32'hABCDE, 32'h13579, 20, 20, 1'b1);
        add_frame(32'h1, 32'h3, 2, 16, 1'b1);
        run_all();
        drain("t_wl_clamp");

        do_reset();
        sample_ready = 1'b0;
        new_stream();
        add_frame(32'h1, 32'h2, 16, 16, 1'b0);
        add_frame(32'h3, 32'h4, 16, 16, 1'b0);
        run_all();
        repeat (10) @(negedge clk);
        chk("t4 valid", 32'(sample_valid), 32'd1);
        chk("t4 left", 32'(left_sample), 32'h0003);
        chk("t4 right", 32'(right_sample), 32'h0004);
`ifdef I2S_RX_OVERRUN_EN
        chk("t4 overrun", 32'(overrun), 32'd1);
`endif
        exp_q.push_back({16'h0003, 16'h0004});
        sample_ready = 1'b1;
        drain("t4_backpressure");

        do_reset();
        sample_ready = 1'b0;
        new_stream();
        add_frame(32'h5555, 32'h6666, 16, 16, 1'b0);
        add_slot(1'b0, 32'h7777, 16, 16);
        add_slot(1'b1, 32'h8888, 16, 16);
        add_frame(32'h1111, 32'h2222, 16, 16, 1'b0);
        add_slot(1'b0, 0, 1, -1);
        play(0, 60);
        repeat (5) @(negedge clk);
        chk("t5 pre valid", 32'(sample_valid), 32'd1);
        chk("t5 pre pair", {left_sample, right_sample}, {16'h5555, 16'h6666});
        reset = 1'b0;
        #1;
        chk("t5 rst left", 32'(left_sample), 32'd0);
        chk("t5 rst right", 32'(right_sample), 32'd0);
        chk("t5 rst valid", 32'(sample_valid), 32'd0);
`ifdef I2S_RX_OVERRUN_EN
        chk("t5 rst overrun", 32'(overrun), 32'd0);
`endif
        #20;
        reset = 1'b1;
        sample_ready = 1'b1;
        exp_q.push_back({16'h1111, 16'h2222});
        play(60, ws_q.size());
        drain("t5_reset_mid");

        for (int run = 0; run < 3; run++) begin
            do_reset();
            new_stream();
            for (int f = 0; f < 8; f++) begin
                s    = $urandom_range(4, 24);
                wl   = $urandom_range(0, 20);
                mask = (32'd1 << s) - 1;
                l    = $urandom & mask;
                r    = $urandom & mask;
                add_frame(l, r, s, wl, 1'b1);
            end
            run_all();
            drain("t6_random");
`ifdef I2S_RX_OVERRUN_EN
            chk("t6 overrun", 32'(overrun), 32'd0);
`endif
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
